// File: rtl/game_tick_gen.sv
// game_tick_gen: multi-channel game timebase.
//
// One programmable-period down-counter produces NUM_CH one-cycle pulses. Channel 0 is the main
// tick; channel i fires i*LEAD cycles before it. Each channel also drives a 50%-duty clock that
// toggles once per pulse. Supports run/pause, a period reload that only takes effect at the
// counter wrap point, and a wrapping count of main ticks.
//
// Optional feature, enabled by defining GAME_TICK_SPEEDUP_EN: every SPEEDUP_TICKS reloads the
// period shrinks by SPEEDUP_STEP, never below MIN_PERIOD. A pending period_load wins at that
// reload and restarts the speed-up interval.
//
// Ports:
//   CLOCK_50       in   1       system clock, all logic on posedge
//   reset          in   1       synchronous active-high reset
//   run            in   1       1 = count, 0 = hold
//   period_in      in   WIDTH   requested period in cycles (clamped to >= 2)
//   period_load    in   1       one-cycle strobe capturing period_in as the pending period
//   pulse          out  NUM_CH  one-cycle tick per channel
//   clk_out        out  NUM_CH  toggled clock per channel
//   tick_count     out  TICK_W  number of channel-0 pulses, wraps
//   period_active  out  WIDTH   period currently in force

module game_tick_gen #(
    parameter int unsigned WIDTH          = 28,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned LEAD           = 15,
    parameter int unsigned DEFAULT_PERIOD = 965664,
    parameter int unsigned TICK_W         = 16,
    parameter int unsigned SPEEDUP_TICKS  = 64,
    parameter int unsigned SPEEDUP_STEP   = 4096,
    parameter int unsigned MIN_PERIOD     = 65536
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              run,
    input  logic [WIDTH-1:0]  period_in,
    input  logic              period_load,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] clk_out,
    output logic [TICK_W-1:0] tick_count,
    output logic [WIDTH-1:0]  period_active
);

    localparam logic [WIDTH-1:0] PeriodRst   = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] PeriodFloor = WIDTH'(2);

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  period_q, period_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    logic [WIDTH-1:0]  load_val;
    logic              wrap;
    logic              take_new;
    logic [WIDTH-1:0]  new_val;

    assign load_val = (period_in < PeriodFloor) ? PeriodFloor : period_in;
    assign wrap     = run && (cnt_q == '0);
    // A load arriving in the reload cycle itself is used for that reload.
    assign take_new = period_load || pend_vld_q;
    assign new_val  = period_load ? load_val : pend_q;

`ifdef GAME_TICK_SPEEDUP_EN
    localparam int unsigned     StW        = (SPEEDUP_TICKS > 1) ? $clog2(SPEEDUP_TICKS) : 1;
    localparam longint unsigned SpeedFloor = longint'(MIN_PERIOD) + longint'(SPEEDUP_STEP);

    logic [StW-1:0]   st_q, st_d;
    logic             st_last;
    logic [WIDTH-1:0] sped_val;

    assign st_last  = (st_q == StW'(SPEEDUP_TICKS - 1));
    // max(period - step, floor) without underflowing the unsigned subtraction.
    assign sped_val = (64'(period_q) >= SpeedFloor) ? (period_q - WIDTH'(SPEEDUP_STEP))
                                                    : WIDTH'(MIN_PERIOD);
`else
    // Speed-up knobs are inert in this build; the block only keeps them referenced.
    if (SPEEDUP_TICKS == 0 || SPEEDUP_STEP == 0 || MIN_PERIOD < 2) begin : g_speedup_cfg_unused
    end
`endif

    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
`ifdef GAME_TICK_SPEEDUP_EN
        st_d       = st_q;
`endif

        if (period_load) begin
            pend_d     = load_val;
            pend_vld_d = 1'b1;
        end

        if (run) begin
            if (cnt_q == '0) begin
                if (take_new) begin
                    period_d   = new_val;
                    pend_vld_d = 1'b0;
`ifdef GAME_TICK_SPEEDUP_EN
                    st_d       = '0;
                end else if (st_last) begin
                    period_d   = sped_val;
                    st_d       = '0;
                end else begin
                    st_d       = st_q + StW'(1);
`endif
                end
                cnt_d = period_d - WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end

        // cnt never exceeds period_active-1, so a channel whose threshold is at or above the
        // active period simply never matches.
        pulse_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pulse_d[i] = run && (64'(cnt_q) == 64'(i) * 64'(LEAD));
        end

        clk_d  = clk_q ^ pulse_q;
        tick_d = tick_q + TICK_W'(wrap);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q      <= PeriodRst - WIDTH'(1);
            period_q   <= PeriodRst;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            pulse_q    <= '0;
            clk_q      <= '0;
            tick_q     <= '0;
`ifdef GAME_TICK_SPEEDUP_EN
            st_q       <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pulse_q    <= pulse_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
`ifdef GAME_TICK_SPEEDUP_EN
            st_q       <= st_d;
`endif
        end
    end

    assign pulse         = pulse_q;
    assign clk_out       = clk_q;
    assign tick_count    = tick_q;
    assign period_active = period_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen (WIDTH=8, NUM_CH=3, LEAD=3, DEFAULT_PERIOD=10, TICK_W=4).
// Directed scenarios push expected observations (cycle, pulse, clk_out, tick_count,
// period_active) into a queue; a monitor pops an entry whenever any pulse is high or an
// entry is due that cycle, and compares.

module tb_game_tick_gen;

    typedef struct {
        int         cyc;
        logic [2:0] pulse;
        logic [2:0] clk;
        logic [3:0] tick;
        logic [7:0] pa;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [7:0] period_in = '0;
    logic       period_load = 1'b0;
    logic [2:0] pulse;
    logic [2:0] clk_out;
    logic [3:0] tick_count;
    logic [7:0] period_active;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic flush = 1'b0;

    game_tick_gen #(
        .WIDTH          (8),
        .NUM_CH         (3),
        .LEAD           (3),
        .DEFAULT_PERIOD (10),
        .TICK_W         (4),
        .SPEEDUP_TICKS  (2),
        .SPEEDUP_STEP   (3),
        .MIN_PERIOD     (4)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .run           (run),
        .period_in     (period_in),
        .period_load   (period_load),
        .pulse         (pulse),
        .clk_out       (clk_out),
        .tick_count    (tick_count),
        .period_active (period_active)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first cycle after the edge that sampled reset high.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed cyc=%0d: nothing observed, required pulse=%b clk=%b tick=%0d per=%0d",
                         exp_q[0].cyc, exp_q[0].pulse, exp_q[0].clk, exp_q[0].tick, exp_q[0].pa);
                void'(exp_q.pop_front());
            end
            if (pulse != 3'b000 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
                n_cmp++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d: got pulse=%b, required none", cyc, pulse);
                end else begin
                    e = exp_q.pop_front();
                    if (pulse !== e.pulse || clk_out !== e.clk || tick_count !== e.tick ||
                        period_active !== e.pa) begin
                        n_fail++;
                        $display("FAIL out cyc=%0d: got pulse=%b clk=%b tick=%0d per=%0d, required pulse=%b clk=%b tick=%0d per=%0d",
                                 cyc, pulse, clk_out, tick_count, period_active,
                                 e.pulse, e.clk, e.tick, e.pa);
                    end
                end
            end
        end
        if (flush) begin
            while (exp_q.size() > 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL never_seen cyc=%0d: required pulse=%b clk=%b tick=%0d per=%0d",
                         exp_q[0].cyc, exp_q[0].pulse, exp_q[0].clk, exp_q[0].tick, exp_q[0].pa);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic push(input int c, input logic [2:0] p, input logic [2:0] k, input int t,
                        input int pa);
        exp_t x;
        x.cyc   = c;
        x.pulse = p;
        x.clk   = k;
        x.tick  = 4'(t);
        x.pa    = 8'(pa);
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input logic run_v);
        reset       = 1'b1;
        run         = 1'b0;
        period_load = 1'b0;
        period_in   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run   = run_v;
    endtask

    // Advance to just after the edge that starts cycle n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b1);
`ifdef GAME_TICK_SPEEDUP_EN
        // Auto speed-up: 10 -> 7 -> 4, then held at the floor.
        push(4,  3'b100, 3'b000, 0, 10);
        push(7,  3'b010, 3'b100, 0, 10);
        push(10, 3'b001, 3'b110, 1, 10);
        push(14, 3'b100, 3'b111, 1, 10);
        push(17, 3'b010, 3'b011, 1, 10);
        push(20, 3'b001, 3'b001, 2, 7);
        push(21, 3'b100, 3'b000, 2, 7);
        push(24, 3'b010, 3'b100, 2, 7);
        push(27, 3'b001, 3'b110, 3, 7);
        push(28, 3'b100, 3'b111, 3, 7);
        push(31, 3'b010, 3'b011, 3, 7);
        push(34, 3'b001, 3'b001, 4, 4);
        push(35, 3'b010, 3'b000, 4, 4);
        push(38, 3'b001, 3'b010, 5, 4);
        push(39, 3'b010, 3'b011, 5, 4);
        push(42, 3'b001, 3'b001, 6, 4);
        goto(43);
`else
        // Free run at the default period.
        push(0,  3'b000, 3'b000, 0, 10);
        push(4,  3'b100, 3'b000, 0, 10);
        push(7,  3'b010, 3'b100, 0, 10);
        push(10, 3'b001, 3'b110, 1, 10);
        push(11, 3'b000, 3'b111, 1, 10);
        push(14, 3'b100, 3'b111, 1, 10);
        push(17, 3'b010, 3'b011, 1, 10);
        push(20, 3'b001, 3'b001, 2, 10);
        push(21, 3'b000, 3'b000, 2, 10);
        push(24, 3'b100, 3'b000, 2, 10);
        push(27, 3'b010, 3'b100, 2, 10);
        push(30, 3'b001, 3'b110, 3, 10);
        push(34, 3'b100, 3'b111, 3, 10);
        push(37, 3'b000, 3'b011, 3, 10);
        goto(35);
        run = 1'b0;
        goto(38);

        // Load period 6 mid-period; applied only at the wrap.
        do_reset(1'b1);
        push(4,  3'b100, 3'b000, 0, 10);
        push(7,  3'b010, 3'b100, 0, 10);
        push(9,  3'b000, 3'b110, 0, 10);
        push(10, 3'b001, 3'b110, 1, 6);
        push(13, 3'b010, 3'b111, 1, 6);
        push(16, 3'b001, 3'b101, 2, 6);
        push(19, 3'b010, 3'b100, 2, 6);
        push(22, 3'b001, 3'b110, 3, 6);
        push(25, 3'b010, 3'b111, 3, 6);
        push(28, 3'b001, 3'b101, 4, 6);
        goto(5);
        period_in   = 8'd6;
        period_load = 1'b1;
        goto(6);
        period_load = 1'b0;
        goto(29);

        // Pauses: cycles 3..12 and 22..27.
        do_reset(1'b1);
        push(8,  3'b000, 3'b000, 0, 10);
        push(14, 3'b100, 3'b000, 0, 10);
        push(17, 3'b010, 3'b100, 0, 10);
        push(20, 3'b001, 3'b110, 1, 10);
        push(25, 3'b000, 3'b111, 1, 10);
        push(30, 3'b100, 3'b111, 1, 10);
        push(33, 3'b010, 3'b011, 1, 10);
        push(36, 3'b001, 3'b001, 2, 10);
        goto(3);
        run = 1'b0;
        goto(13);
        run = 1'b1;
        goto(22);
        run = 1'b0;
        goto(28);
        run = 1'b1;
        goto(37);

        // Clamp of 0 and 1 to period 2, tick_count wrap, then reset with a load pending.
        do_reset(1'b1);
        push(4, 3'b100, 3'b000, 0, 10);
        push(7, 3'b010, 3'b100, 0, 10);
        for (int k = 1; k <= 18; k++) begin
            push(8 + 2 * k, 3'b001, {2'b11, 1'((k - 1) % 2)}, k % 16, 2);
        end
        goto(1);
        period_in   = 8'd0;
        period_load = 1'b1;
        goto(2);
        period_load = 1'b0;
        goto(13);
        period_in   = 8'd1;   // same cycle as a reload
        period_load = 1'b1;
        goto(14);
        period_load = 1'b0;
        goto(44);
        period_in   = 8'd5;   // must be discarded by the reset below
        period_load = 1'b1;
        goto(45);
        do_reset(1'b1);
        push(0,  3'b000, 3'b000, 0, 10);
        push(4,  3'b100, 3'b000, 0, 10);
        push(7,  3'b010, 3'b100, 0, 10);
        push(10, 3'b001, 3'b110, 1, 10);
        goto(12);
`endif
        flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
